// File: rtl/pcw_boot_sequencer_if.sv
// Download-port bundle between the boot sequencer and the PCW core.
// Master drives the write side, slave (core) drives the stall.
interface pcw_boot_sequencer_if #(
  parameter int ADDR_W = 16
) ();
  logic              dn_go;
  logic              dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wait;

  modport master (
    output dn_go,
    output dn_wr,
    output dn_addr,
    output dn_data,
    input  dn_wait
  );

  modport slave (
    input  dn_go,
    input  dn_wr,
    input  dn_addr,
    input  dn_data,
    output dn_wait
  );
endinterface

// File: rtl/pcw_boot_sequencer.sv
// Boot ROM to core-memory copy engine.
// One byte per READ/LATCH/WRITE round, then an EXEC pulse.
module pcw_boot_sequencer #(
  parameter int              ROM_LEN   = 276,
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] DN_BASE   = '0,
  parameter logic [ADDR_W-1:0] EXEC_ADDR = '0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  pcw_boot_sequencer_if.master dn,
  output logic [ADDR_W-1:0] execute_addr,
  output logic              execute_enable,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(ROM_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_WRITE,
    S_EXEC
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_go;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_exec;
  logic              r_done;

  logic [ADDR_W-1:0] w_idx_nxt;
  logic              w_last;
  logic              w_accept;

  assign w_idx_nxt = r_idx + 1'b1;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_accept  = ~dn.dn_wait;

  // Sequencer: one state register, every output registered here.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_rom_addr <= '0;
      r_go       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_exec     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx      <= '0;
            r_rom_addr <= '0;
            r_go       <= 1'b1;
            r_done     <= 1'b0;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_data  <= rom_data;
          r_addr  <= DN_BASE + r_idx;
          r_wr    <= 1'b1;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (w_accept) begin
            r_wr <= 1'b0;
            if (w_last) begin
              r_go    <= 1'b0;
              r_exec  <= 1'b1;
              r_state <= S_EXEC;
            end else begin
              r_idx      <= w_idx_nxt;
              r_rom_addr <= w_idx_nxt;
              r_state    <= S_READ;
            end
          end
        end
        S_EXEC: begin
          r_exec  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr       = r_rom_addr;
  assign dn.dn_go       = r_go;
  assign dn.dn_wr       = r_wr;
  assign dn.dn_addr     = r_addr;
  assign dn.dn_data     = r_data;
  assign execute_addr   = EXEC_ADDR;
  assign execute_enable = r_exec;
  assign done           = r_done;

endmodule

// File: tb/tb_pcw_boot_sequencer.sv
// Scoreboard bench for pcw_boot_sequencer.
// Main 276-byte instance plus two tiny wrap-around instances.
module tb_pcw_boot_sequencer;

  localparam int          AW   = 16;
  localparam int          LEN  = 276;
  localparam logic [15:0] BASE = 16'h0000;
  localparam logic [15:0] WB   = 16'hFFFF;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic st_w    = 1'b0;

  always #5 clk_sys = ~clk_sys;

  logic [15:0] rom_addr, exe_addr;
  logic [7:0]  rom_data;
  logic        exe, done;

  logic [15:0] w1_ra, w1_xa, w2_ra, w2_xa;
  logic [7:0]  w1_rd, w2_rd;
  logic        w1_ex, w1_dn, w2_ex, w2_dn;

  pcw_boot_sequencer_if #(.ADDR_W(AW)) dn ();
  pcw_boot_sequencer_if #(.ADDR_W(AW)) w1 ();
  pcw_boot_sequencer_if #(.ADDR_W(AW)) w2 ();

  assign w1.dn_wait = 1'b0;
  assign w2.dn_wait = 1'b0;

  pcw_boot_sequencer #(
    .ROM_LEN(LEN), .ADDR_W(AW),
    .DN_BASE(BASE), .EXEC_ADDR(16'h0000)
  ) u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .dn(dn),
    .execute_addr(exe_addr),
    .execute_enable(exe), .done(done)
  );

  pcw_boot_sequencer #(
    .ROM_LEN(1), .ADDR_W(AW),
    .DN_BASE(WB), .EXEC_ADDR(16'h0000)
  ) u_w1 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .start(st_w), .rom_addr(w1_ra),
    .rom_data(w1_rd), .dn(w1),
    .execute_addr(w1_xa),
    .execute_enable(w1_ex), .done(w1_dn)
  );

  pcw_boot_sequencer #(
    .ROM_LEN(2), .ADDR_W(AW),
    .DN_BASE(WB), .EXEC_ADDR(16'h0000)
  ) u_w2 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .start(st_w), .rom_addr(w2_ra),
    .rom_data(w2_rd), .dn(w2),
    .execute_addr(w2_xa),
    .execute_enable(w2_ex), .done(w2_dn)
  );

  // Synchronous boot ROMs: ROM[i] = i ^ A5
  always @(posedge clk_sys) begin
    rom_data <= rom_addr[7:0] ^ 8'hA5;
    w1_rd    <= w1_ra[7:0] ^ 8'hA5;
    w2_rd    <= w2_ra[7:0] ^ 8'hA5;
  end

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t q[$];
  bit   m_busy = 0;
  bit   m_go   = 0;
  bit   m_done = 0;
  int   exec_cyc = -1;
  int   prev_cyc = 0;
  int   stalls   = 0;
  int   n_exec   = 0;

  // Reference: a load is the list of (BASE+i, i^A5),
  // one accept every 3 cycles plus one per stall cycle.
  task automatic push_load();
    exp_t e;
    for (int i = 0; i < LEN; i++) begin
      e.a = BASE + 16'(i);
      e.d = 8'(i) ^ 8'hA5;
      q.push_back(e);
    end
  endtask

  // Monitor: compares the DUT against the model mid-cycle.
  always @(negedge clk_sys) begin
    exp_t e;
    if (!reset_n) begin
      chk("reset_outs",
          {rom_addr, dn.dn_go, dn.dn_wr, dn.dn_addr,
           dn.dn_data, exe, done}, '0);
      q.delete();
      m_busy   = 0;
      m_go     = 0;
      m_done   = 0;
      exec_cyc = -1;
      stalls   = 0;
    end else begin
      chk("dn_go", dn.dn_go, m_go);
      chk("done", done, m_done);
      chk("exec_en", exe, cyc == exec_cyc);
      chk("exec_addr", exe_addr, 16'h0000);
      if (exe) n_exec++;
      if (dn.dn_wr) begin
        chk("wr_with_exec", exe, 1'b0);
        if (q.size() == 0) begin
          chk("spurious_wr", dn.dn_wr, 1'b0);
        end else if (dn.dn_wait) begin
          stalls++;
          chk("stall_addr", dn.dn_addr, q[0].a);
          chk("stall_data", dn.dn_data, q[0].d);
        end else begin
          e = q.pop_front();
          chk("wr_addr", dn.dn_addr, e.a);
          chk("wr_data", dn.dn_data, e.d);
          chk("wr_cycle", cyc, prev_cyc + 3 + stalls);
          prev_cyc = cyc;
          stalls   = 0;
          if (q.size() == 0) begin
            m_go     = 0;
            exec_cyc = cyc + 1;
          end
        end
      end
      if (start && !m_busy) begin
        push_load();
        m_busy   = 1;
        m_go     = 1;
        m_done   = 0;
        prev_cyc = cyc;
        stalls   = 0;
      end
      if (cyc == exec_cyc) begin
        m_done = 1;
        m_busy = 0;
      end
    end
  end

  bit rnd_wait = 0;

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (rnd_wait)
      dn.dn_wait = ($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 4000) begin
      tick();
      n++;
    end
    chk("load_timeout", m_busy, 1'b0);
  endtask

  task automatic wait_byte(input logic [15:0] a);
    int n = 0;
    while (!(dn.dn_wr && dn.dn_addr == a) && n < 4000) begin
      tick();
      n++;
    end
    chk("reach_byte", dn.dn_wr && dn.dn_addr == a, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic small_chk(input string nm, input int L,
                           input int k,
                           input logic go,
                           input logic wr,
                           input logic [15:0] a,
                           input logic [7:0] d,
                           input logic ex,
                           input logic dn_);
    int          idx;
    logic [15:0] ea;
    logic        ewr;
    idx = k / 3;
    ea  = WB + 16'(idx);
    ewr = (k % 3 == 2) && (k < 3 * L);
    chk({nm, "_go"}, go, k < 3 * L);
    chk({nm, "_wr"}, wr, ewr);
    if (ewr) begin
      chk({nm, "_addr"}, a, ea);
      chk({nm, "_data"}, d, 8'(idx) ^ 8'hA5);
    end
    chk({nm, "_exec"}, ex, k == 3 * L);
    chk({nm, "_done"}, dn_, k >= 3 * L + 1);
  endtask

  initial begin
    int n;
    dn.dn_wait = 1'b0;
    reset_n    = 1'b0;
    repeat (3) tick();
    chk("rst_main",
        {rom_addr, dn.dn_go, dn.dn_wr, dn.dn_addr,
         dn.dn_data, exe, done}, '0);
    chk("rst_small",
        {w1.dn_go, w1.dn_wr, w1_dn, w2.dn_go, w2.dn_wr, w2_dn},
        '0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Nominal load
    pulse_start();
    wait_idle();
    repeat (3) tick();

    // Five-cycle stall on byte 10, ignored start at byte 100
    pulse_start();
    wait_byte(16'd10);
    dn.dn_wait = 1'b1;
    repeat (5) tick();
    dn.dn_wait = 1'b0;
    wait_byte(16'd100);
    pulse_start();
    wait_idle();
    repeat (3) tick();

    // Asynchronous reset in the middle of byte 50
    pulse_start();
    wait_byte(16'd50);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid",
        {rom_addr, dn.dn_go, dn.dn_wr, dn.dn_addr,
         dn.dn_data, exe, done}, '0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    pulse_start();
    wait_idle();
    repeat (2) tick();

    // Random stalls and stray start pulses
    rnd_wait = 1;
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      n = 0;
      while (m_busy && n < 6000) begin
        tick();
        start = ($urandom_range(0, 60) == 0);
        n++;
      end
      start = 1'b0;
      wait_idle();
      repeat ($urandom_range(1, 4)) tick();
    end
    rnd_wait   = 0;
    dn.dn_wait = 1'b0;
    repeat (2) tick();

    // Start held high: back-to-back loads
    start = 1'b1;
    repeat (2000) tick();
    start = 1'b0;
    wait_idle();
    repeat (3) tick();
    chk("exec_total", n_exec, 8);

    // ROM_LEN 1 and 2 with base FFFF
    st_w = 1'b1;
    tick();
    st_w = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      small_chk("w1", 1, k, w1.dn_go, w1.dn_wr,
                w1.dn_addr, w1.dn_data, w1_ex, w1_dn);
      small_chk("w2", 2, k, w2.dn_go, w2.dn_wr,
                w2.dn_addr, w2.dn_data, w2_ex, w2_dn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
